// File: rtl/bcd4binary_pkg.sv
//------------------------------------------------------------------------------
// Module   : bcd4binary_pkg
// Purpose  : Shared constants and digit helpers for the BCD -> binary converter
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package bcd4binary_pkg;

    localparam int          c_VALUE_W = 14;
    localparam int          c_DIGIT_W = 4;
    localparam logic [3:0]  c_BLANK   = 4'hF;

    localparam logic [1:0]  c_S_IDLE  = 2'b00;
    localparam logic [1:0]  c_S_ACCUM = 2'b01;
    localparam logic [1:0]  c_S_DONE  = 2'b10;

    // Blank digits contribute nothing to the sum.
    function automatic logic [c_DIGIT_W-1:0] digit_value(input logic [c_DIGIT_W-1:0] d);
        return (d == c_BLANK) ? '0 : d;
    endfunction

    function automatic logic digit_invalid(input logic [c_DIGIT_W-1:0] d);
        return (d >= 4'hA) && (d <= 4'hE);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd4binary_mul10add.sv
//------------------------------------------------------------------------------
// Module   : bcd4binary_mul10add
// Purpose  : acc_out = acc_in * 10 + digit using shifts and adds, modulo 2^W
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd4binary_mul10add #(
    parameter int VALUE_W = 14
) (
    input  logic [VALUE_W-1:0] acc_in,
    input  logic [3:0]         digit,
    output logic [VALUE_W-1:0] acc_out
);

    logic [VALUE_W-1:0] w_x8;
    logic [VALUE_W-1:0] w_x2;
    logic [VALUE_W-1:0] w_dig;

    assign w_x8    = {acc_in[VALUE_W-4:0], 3'b000};
    assign w_x2    = {acc_in[VALUE_W-2:0], 1'b0};
    assign w_dig   = {{(VALUE_W-4){1'b0}}, digit};
    assign acc_out = w_x8 + w_x2 + w_dig;

endmodule

`default_nettype wire

// File: rtl/bcd4binary.sv
//------------------------------------------------------------------------------
// Module   : bcd4binary
// Purpose  : Sequential 4-digit BCD -> 14-bit binary converter, MSD first,
//            one digit per cycle. Define BCD2BIN_ERR_EN to flag nibbles A..E.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd4binary
    import bcd4binary_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [3:0]           A,
    input  logic [3:0]           B,
    input  logic [3:0]           C,
    input  logic [3:0]           D,
    output logic                 ready,
    output logic                 valid,
    output logic [c_VALUE_W-1:0] value,
    output logic                 err
);

    logic [1:0]            r_state;
    logic [1:0]            r_dig_sel;
    logic [3:0][3:0]       r_shadow;
    logic [c_VALUE_W-1:0]  r_acc;

    logic [3:0]            w_digit;
    logic [c_VALUE_W-1:0]  w_acc_next;
    logic [c_VALUE_W-1:0]  w_result;
    logic                  w_accept;
    logic                  w_finish;

    assign w_accept = (r_state == c_S_IDLE) && start;
    assign w_finish = (r_state == c_S_ACCUM) && (r_dig_sel == 2'd0);
    assign w_digit  = digit_value(r_shadow[r_dig_sel]);

    bcd4binary_mul10add #(
        .VALUE_W (c_VALUE_W)
    ) u_mul10add (
        .acc_in  (r_acc),
        .digit   (w_digit),
        .acc_out (w_acc_next)
    );

`ifdef BCD2BIN_ERR_EN
    logic r_bad;
    logic w_in_bad;

    assign w_in_bad = digit_invalid(A) | digit_invalid(B) |
                      digit_invalid(C) | digit_invalid(D);
    assign w_result = r_bad ? '0 : w_acc_next;

    // err is sticky until the next accepted start.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bad <= 1'b0;
            err   <= 1'b0;
        end else if (w_accept) begin
            r_bad <= w_in_bad;
            err   <= 1'b0;
        end else if (w_finish) begin
            err   <= r_bad;
        end
    end
`else
    assign w_result = w_acc_next;
    assign err      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= c_S_IDLE;
            r_dig_sel <= 2'd3;
            r_shadow  <= '0;
            r_acc     <= '0;
            ready     <= 1'b1;
            valid     <= 1'b0;
            value     <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    valid <= 1'b0;
                    ready <= 1'b1;
                    if (start) begin
                        r_shadow  <= {D, C, B, A};
                        r_acc     <= '0;
                        r_dig_sel <= 2'd3;
                        ready     <= 1'b0;
                        r_state   <= c_S_ACCUM;
                    end
                end
                c_S_ACCUM: begin
                    r_acc <= w_acc_next;
                    if (r_dig_sel == 2'd0) begin
                        value   <= w_result;
                        valid   <= 1'b1;
                        r_state <= c_S_DONE;
                    end else begin
                        r_dig_sel <= r_dig_sel - 2'd1;
                    end
                end
                c_S_DONE: begin
                    valid   <= 1'b0;
                    ready   <= 1'b1;
                    r_state <= c_S_IDLE;
                end
                default: begin
                    valid   <= 1'b0;
                    ready   <= 1'b1;
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
